atto_pe_link: RTL

PE-side link controller for the atto router's local port. It is the other end of the router's PE channel. It packs PE requests into 48-bit flits, drives them onto the router's PE input with two-phase complementary-pair signalling and waits for the router's acknowledge. It also decodes flits ejected by the router on its PE output and buffers them for the processing element.

---
 rtl/atto_pe_link.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/atto_pe_link.sv
// rtl/atto_pe_link.sv - PE-side link for the atto router local port: flit injection with ack/timeout, ejection FIFO.
// Optional ATTO_PE_LINK_DIFF_CHECK_EN: flag illegal two-phase pair codes on RX and check TX codes in simulation.
module atto_pe_link #(
   parameter int RX_DEPTH    = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clka,
   input  logic        rsta,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [3:0]  tx_dest_x,
   input  logic [3:0]  tx_dest_y,
   input  logic [39:0] tx_payload,
   output logic [47:0] pe_channel_din,
   output logic [1:0]  pe_diff_pair_din,
   input  logic        r2pe_ack_dout,
   input  logic [39:0] pe_channel_dout,
   input  logic [1:0]  pe_diff_pair_dout,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [39:0] rx_payload,
   output logic        rx_overflow,
   output logic        tx_timeout,
   output logic        diff_err,
   input  logic        clear_flags
);

   localparam int PW = $clog2(RX_DEPTH);
   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

   state_t         r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic           w_accept, w_tout_fire;
   logic [47:0]    r_chan_din;
   logic [1:0]     r_pair_din;
   logic           r_tx_timeout;

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ack is checked before the counter so an ack on the expiry cycle wins.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_tout_fire = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tx_valid) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (r2pe_ack_dout) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
               if (w_cnt_nxt == CW'(ACK_TIMEOUT)) begin
                  w_tout_fire = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         r_cnt        <= '0;
         r_chan_din   <= '0;
         r_pair_din   <= 2'b10;
         r_tx_timeout <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_accept) begin
            r_chan_din <= {tx_dest_x, tx_dest_y, tx_payload};
            r_pair_din <= ~r_pair_din;
         end
         if (w_tout_fire) begin
            r_tx_timeout <= 1'b1;
         end else if (clear_flags) begin
            r_tx_timeout <= 1'b0;
         end
      end
   end

   assign tx_ready         = (r_state == S_IDLE);
   assign pe_channel_din   = r_chan_din;
   assign pe_diff_pair_din = r_pair_din;
   assign tx_timeout       = r_tx_timeout;

   logic [39:0]   r_mem [RX_DEPTH];
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [PW:0]   r_count;
   logic [1:0]    r_last_pair;
   logic          r_rx_overflow;
   logic          w_legal, w_event, w_full, w_pop, w_push, w_drop, w_rx_valid;

   // A legal code differing from the last one is a new flit; the level itself is meaningless.
   assign w_legal    = ^pe_diff_pair_dout;
   assign w_event    = w_legal && (pe_diff_pair_dout != r_last_pair);
   assign w_rx_valid = (r_count != '0);
   assign w_full     = (r_count == (PW+1)'(RX_DEPTH));
   assign w_pop      = w_rx_valid && rx_ready;
   assign w_push     = w_event && (!w_full || w_pop);
   assign w_drop     = w_event && w_full && !w_pop;

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         for (int i = 0; i < RX_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_last_pair   <= 2'b10;
         r_rx_overflow <= 1'b0;
      end else begin
         if (w_event) begin
            r_last_pair <= pe_diff_pair_dout;
         end
         if (w_push) begin
            r_mem[r_wr_ptr] <= pe_channel_dout;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_rx_overflow <= 1'b1;
         end else if (clear_flags) begin
            r_rx_overflow <= 1'b0;
         end
      end
   end

   assign rx_valid    = w_rx_valid;
   assign rx_payload  = r_mem[r_rd_ptr];
   assign rx_overflow = r_rx_overflow;

`ifdef ATTO_PE_LINK_DIFF_CHECK_EN
   logic r_diff_err;

   always_ff @(posedge clka or posedge rsta) begin
      if (rsta) begin
         r_diff_err <= 1'b0;
      end else if (!w_legal) begin
         r_diff_err <= 1'b1;
      end else if (clear_flags) begin
         r_diff_err <= 1'b0;
      end
   end

   assign diff_err = r_diff_err;

   a_tx_pair_legal: assert property (@(posedge clka) disable iff (rsta) (^r_pair_din));
`else
   assign diff_err = 1'b0;
`endif

endmodule
